// File: rtl/pc_ir_unit.sv
// Fetch-side register stage of the multicycle MIPS datapath: PC, IR and ALUOut registers,
// instruction field decode, retired-fetch counter and a sticky misaligned-PC trap.
module pc_ir_unit #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(32'h0040_0000),
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCWrite,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              PCSrc,
  input  logic              Jump,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] alu_out,
  output logic [5:0]        Opcode,
  output logic [5:0]        Funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] imm_sext,
  output logic [DATA_W-1:0] imm_zext,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              misalign,
  output logic [DATA_W-1:0] bad_pc
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] bad_pc_q, bad_pc_d;

  logic              pc_en;
  logic [DATA_W-1:0] target;
  logic              target_ok;

  assign pc_en = PCWrite | (Branch & Zero);

  // Jump keeps the upper PC nibble and splices in the word-aligned 26-bit index.
  always_comb begin
    target = ALUResult;
    if (Jump) begin
      target        = pc_q;
      target[27:0]  = {ir_q[25:0], 2'b00};
    end else if (PCSrc) begin
      target = alu_out_q;
    end
  end

  assign target_ok = (target[1:0] == 2'b00);

  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    alu_out_d     = ALUResult;
    fetch_count_d = fetch_count_q;
    misalign_d    = misalign_q;
    bad_pc_d      = bad_pc_q;

    if (pc_en) begin
      if (target_ok) begin
        pc_d = target;
      end else begin
        misalign_d = 1'b1;
        // Only the first rejected address is kept for debug.
        if (!misalign_q) begin
          bad_pc_d = target;
        end
      end
    end

    if (IRWrite) begin
      ir_d          = mem_rdata;
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      alu_out_q     <= '0;
      fetch_count_q <= '0;
      misalign_q    <= 1'b0;
      bad_pc_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      alu_out_q     <= alu_out_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
      bad_pc_q      <= bad_pc_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign alu_out     = alu_out_q;
  assign fetch_count = fetch_count_q;
  assign misalign    = misalign_q;
  assign bad_pc      = bad_pc_q;

  // Field decode straight from the IR flops, so the outputs only change at clock edges.
  assign Opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign Funct    = ir_q[5:0];
  assign imm_sext = {{(DATA_W - 16){ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {{(DATA_W - 16){1'b0}}, ir_q[15:0]};

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: a driver pushes model-predicted register state per event,
// a monitor pops and compares after every clock edge or asynchronous reset assertion.
module tb_pc_ir_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              PCWrite, Branch, Zero, PCSrc, Jump, IRWrite;
  logic [DATA_W-1:0] mem_rdata, ALUResult;
  logic [DATA_W-1:0] pc, ir, alu_out, imm_sext, imm_zext, bad_pc;
  logic [5:0]        Opcode, Funct;
  logic [4:0]        rs, rt, rd;
  logic [CNT_W-1:0]  fetch_count;
  logic              misalign;

  pc_ir_unit #(
    .DATA_W  (DATA_W),
    .RESET_PC(RST_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .Zero       (Zero),
    .PCSrc      (PCSrc),
    .Jump       (Jump),
    .IRWrite    (IRWrite),
    .mem_rdata  (mem_rdata),
    .ALUResult  (ALUResult),
    .pc         (pc),
    .ir         (ir),
    .alu_out    (alu_out),
    .Opcode     (Opcode),
    .Funct      (Funct),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm_sext   (imm_sext),
    .imm_zext   (imm_zext),
    .fetch_count(fetch_count),
    .misalign   (misalign),
    .bad_pc     (bad_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu;
    int          cnt;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_ir, m_alu, m_bad;
  int          m_cnt;
  logic        m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.ir = m_ir; e.alu = m_alu; e.cnt = m_cnt; e.mis = m_mis; e.bad = m_bad;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_ir = 0; m_alu = 0; m_cnt = 0; m_mis = 0; m_bad = 0;
  endtask

  // Apply one cycle of controller strobes (called just after a falling edge).
  task automatic drive(input logic pcw, input logic br, input logic z, input logic src,
                       input logic jmp, input logic irw, input logic [31:0] rdata,
                       input logic [31:0] alu);
    logic [31:0] tgt;
    PCWrite = pcw; Branch = br; Zero = z; PCSrc = src; Jump = jmp; IRWrite = irw;
    mem_rdata = rdata; ALUResult = alu;
    if (jmp)      tgt = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
    else if (src) tgt = m_alu;
    else          tgt = alu;
    if (pcw || (br && z)) begin
      if (tgt % 4 == 0) begin
        m_pc = tgt;
      end else begin
        if (!m_mis) m_bad = tgt;
        m_mis = 1'b1;
      end
    end
    if (irw) begin
      m_ir  = rdata;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    m_alu = alu;
    sb.push_back(snap());
    @(negedge clk);
  endtask

  // Assert reset between edges; one entry for the immediate effect, one for the next edge.
  task automatic async_reset();
    PCWrite = 1'b1; IRWrite = 1'b1; ALUResult = 32'h0040_1000; mem_rdata = $urandom;
    model_reset();
    sb.push_back(snap());
    sb.push_back(snap());
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic signed [15:0] h;
    logic [31:0] sext;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        h = e.ir[15:0];
        sext = int'(h);
        chk("pc", pc, e.pc);
        chk("ir", ir, e.ir);
        chk("alu_out", alu_out, e.alu);
        chk("fetch_count", 32'(fetch_count), e.cnt);
        chk("misalign", 32'(misalign), 32'(e.mis));
        chk("bad_pc", bad_pc, e.bad);
        chk("Opcode", 32'(Opcode), e.ir >> 26);
        chk("rs", 32'(rs), (e.ir >> 21) % 32);
        chk("rt", 32'(rt), (e.ir >> 16) % 32);
        chk("rd", 32'(rd), (e.ir >> 11) % 32);
        chk("Funct", 32'(Funct), e.ir % 64);
        chk("imm_sext", imm_sext, sext);
        chk("imm_zext", imm_zext, e.ir % 65536);
      end
    end
  end

  initial begin
    logic [31:0] a, w;
    PCWrite = 0; Branch = 0; Zero = 0; PCSrc = 0; Jump = 0; IRWrite = 0;
    mem_rdata = 0; ALUResult = 0;
    model_reset();
    @(negedge clk);
    PCWrite = 1; IRWrite = 1; mem_rdata = 32'hDEAD_BEEF; ALUResult = 32'h1234_5678;
    sb.push_back(snap());
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch: addi word, PC+4
    drive(1, 0, 0, 0, 0, 1, 32'h2008_000A, 32'h0040_0004);
    // Fetch the J word while moving to 0x00400008, then jump
    drive(1, 0, 0, 0, 0, 1, 32'h0810_0010, 32'h0040_0008);
    drive(1, 0, 0, 0, 1, 0, 32'h0, 32'h0000_0100);
    // Branch via ALUOut
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0040_0020);
    drive(0, 1, 0, 1, 0, 0, 32'h0, 32'h0040_0020);
    drive(0, 1, 1, 1, 0, 0, 32'h0, 32'h0040_0020);
    // Jump without enable is ignored
    drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h0040_0020);
    // Misaligned targets: first kept, later aligned updates still apply
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0040_0006);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0040_0003);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0040_0010);
    // ORI immediate
    drive(0, 0, 0, 0, 0, 1, 32'h3508_FFFF, 32'h0);
    // Async reset mid-sequence
    async_reset();

    // Counter wrap with bursts of fetches
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, $urandom, $urandom);
    end

    // Randomized controller strobes
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
      w = ($urandom_range(0, 3) == 0) ? {6'h02, 26'($urandom)} : 32'($urandom);
      drive(1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), w, a);
      if (i == 150) async_reset();
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, 0 required", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
